// File: rtl/wb_initiator.sv
// Wishbone classic single-cycle initiator: turns one valid/ready request into one
// bus read or write, with a bus timeout and a post-cycle quiet gap for lingering acks.
module wb_initiator #(
   parameter int DAT_W    = 32,
   parameter int ADR_W    = 32,
   parameter int TIMEOUT  = 255,
   parameter int IDLE_GAP = 2
) (
   input  logic               clk_i,
   input  logic               rst_i,
   // requester side
   input  logic               req_valid_i,
   output logic               req_ready_o,
   input  logic               req_we_i,
   input  logic [ADR_W-1:0]   req_adr_i,
   input  logic [DAT_W-1:0]   req_dat_i,
   input  logic [DAT_W/8-1:0] req_sel_i,
   output logic               rsp_valid_o,
   output logic [DAT_W-1:0]   rsp_dat_o,
   output logic               rsp_err_o,
   // Wishbone master side
   output logic               wbm_cyc_o,
   output logic               wbm_stb_o,
   output logic               wbm_we_o,
   output logic [ADR_W-1:0]   wbm_adr_o,
   output logic [DAT_W-1:0]   wbm_dat_o,
   output logic [DAT_W/8-1:0] wbm_sel_o,
   input  logic [DAT_W-1:0]   wbm_dat_i,
   input  logic               wbm_ack_i,
   input  logic               wbm_err_i,
   output logic               busy_o
);

   localparam int SEL_W = DAT_W / 8;
   localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
   localparam logic [3:0]       GAP_LAST = 4'((IDLE_GAP > 0) ? IDLE_GAP - 1 : 0);

   typedef enum logic [1:0] {
      S_IDLE,
      S_BUS,
      S_GAP
   } state_e;

   state_e             state_q,     state_d;
   logic [CNT_W-1:0]   tmo_cnt_q,   tmo_cnt_d;
   logic [3:0]         gap_cnt_q,   gap_cnt_d;
   logic               we_q,        we_d;
   logic [ADR_W-1:0]   adr_q,       adr_d;
   logic [DAT_W-1:0]   dat_q,       dat_d;
   logic [SEL_W-1:0]   sel_q,       sel_d;
   logic               rsp_valid_q, rsp_valid_d;
   logic               rsp_err_q,   rsp_err_d;
   logic [DAT_W-1:0]   rsp_dat_q,   rsp_dat_d;
   logic               timeout_hit;

   // Terminating at TIMEOUT-1 means the counter can never wrap while it matters.
   assign timeout_hit = (TIMEOUT != 0) && (tmo_cnt_q == CNT_LAST);

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      state_d     = state_q;
      tmo_cnt_d   = tmo_cnt_q;
      gap_cnt_d   = gap_cnt_q;
      we_d        = we_q;
      adr_d       = adr_q;
      dat_d       = dat_q;
      sel_d       = sel_q;
      rsp_valid_d = 1'b0;
      rsp_err_d   = 1'b0;
      rsp_dat_d   = '0;

      unique case (state_q)
         S_IDLE: begin
            if (req_valid_i) begin
               we_d      = req_we_i;
               adr_d     = req_adr_i;
               dat_d     = req_dat_i;
               sel_d     = req_sel_i;
               tmo_cnt_d = '0;
               state_d   = S_BUS;
            end
         end
         S_BUS: begin
            if (wbm_err_i || wbm_ack_i || timeout_hit) begin
               rsp_valid_d = 1'b1;
               // err outranks ack; with neither present this is the timeout
               rsp_err_d   = wbm_err_i || !wbm_ack_i;
               if (!wbm_err_i && wbm_ack_i && !we_q) begin
                  rsp_dat_d = wbm_dat_i;
               end
               gap_cnt_d = '0;
               state_d   = (IDLE_GAP > 0) ? S_GAP : S_IDLE;
            end else if (TIMEOUT != 0) begin
               tmo_cnt_d = tmo_cnt_q + 1'b1;
            end
         end
         S_GAP: begin
            if (gap_cnt_q == GAP_LAST) begin
               state_d = S_IDLE;
            end else begin
               gap_cnt_d = gap_cnt_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      if (rst_i) begin
         state_q     <= S_IDLE;
         tmo_cnt_q   <= '0;
         gap_cnt_q   <= '0;
         we_q        <= 1'b0;
         adr_q       <= '0;
         dat_q       <= '0;
         sel_q       <= '0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_dat_q   <= '0;
      end else begin
         state_q     <= state_d;
         tmo_cnt_q   <= tmo_cnt_d;
         gap_cnt_q   <= gap_cnt_d;
         we_q        <= we_d;
         adr_q       <= adr_d;
         dat_q       <= dat_d;
         sel_q       <= sel_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         rsp_dat_q   <= rsp_dat_d;
      end
   end

   assign req_ready_o = (state_q == S_IDLE);
   assign busy_o      = (state_q != S_IDLE);
   assign wbm_cyc_o   = (state_q == S_BUS);
   assign wbm_stb_o   = (state_q == S_BUS);
   assign wbm_we_o    = we_q;
   assign wbm_adr_o   = adr_q;
   assign wbm_dat_o   = dat_q;
   assign wbm_sel_o   = sel_q;
   assign rsp_valid_o = rsp_valid_q;
   assign rsp_err_o   = rsp_err_q;
   assign rsp_dat_o   = rsp_dat_q;

endmodule
